// File: rtl/kronos_if.sv
// Instruction fetch stage: issues fetch requests from an internal pc and presents {pc, ir} to decode.
// Latency: a fetch appears on the edge that accepts instr_ack, so zero-wait memory sustains one instruction per cycle.
// Backpressure: if decode stalls while an ack lands, the word is parked in a one-entry skid buffer and requests pause until decode drains it.
//
// Ports:
//   clk, rstz                  - clock, asynchronous active-low reset
//   instr_addr, instr_req      - fetch request to instruction memory (addr is the internal pc)
//   instr_data, instr_ack      - memory response; data is only meaningful with ack
//   branch, branch_target      - single-cycle redirect, overrides every other event
//   fetch, fetch_vld, fetch_rdy- {pc, ir} toward decode with valid/ready handshake
module kronos_if #(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [63:0] fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2
    } state_t;

    // Layout matches the decode-stage view: pc in the upper word, ir in the lower.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipe_ifid_t;

    state_t      state;
    logic [31:0] pc;
    pipe_ifid_t  fetch_q;
    pipe_ifid_t  skid;

    logic        slot_free;
    logic [31:0] pc_inc;

    assign instr_addr = pc;
    assign fetch      = fetch_q;

    // The output register can take a new word if it is empty or being drained this edge.
    assign slot_free  = !fetch_vld || fetch_rdy;
    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign pc_inc     = pc + 32'd4;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state     <= BOOT;
            pc        <= BOOT_ADDR;
            fetch_q   <= '0;
            fetch_vld <= 1'b0;
            skid      <= '0;
            instr_req <= 1'b0;
        end else if (branch) begin
            // Redirect wins over everything, including an ack arriving this same
            // edge: that response and any parked skid word belong to the old path.
            state     <= FETCH;
            pc        <= branch_target;
            fetch_vld <= 1'b0;
            skid      <= '0;
            instr_req <= 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    state     <= FETCH;
                    instr_req <= 1'b1;
                end

                FETCH: begin
                    // instr_req is always high here, so any ack belongs to pc.
                    if (instr_ack) begin
                        pc <= pc_inc;
                        if (slot_free) begin
                            fetch_q   <= '{pc: pc, ir: instr_data};
                            fetch_vld <= 1'b1;
                        end else begin
                            // Decode is holding the current word; park this one and
                            // stop requesting so at most two words are in flight.
                            skid      <= '{pc: pc, ir: instr_data};
                            state     <= STALL;
                            instr_req <= 1'b0;
                        end
                    end else if (fetch_vld && fetch_rdy) begin
                        fetch_vld <= 1'b0;
                    end
                end

                STALL: begin
                    // No request is outstanding, so acks seen here are ignored.
                    if (fetch_rdy) begin
                        fetch_q   <= skid;
                        state     <= FETCH;
                        instr_req <= 1'b1;
                    end
                end

                default: begin
                    state     <= BOOT;
                    instr_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_if.sv
// Directed bench for kronos_if: drives memory/decode/branch inputs one cycle at a time
// and checks outputs #1 after each rising edge against hand-computed values.
module tb_kronos_if;

    logic        clk;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic        branch;
    logic [31:0] branch_target;
    logic [63:0] fetch;
    logic        fetch_vld;
    logic        fetch_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    kronos_if #(.BOOT_ADDR(32'h0)) dut (
        .clk           (clk),
        .rstz          (rstz),
        .instr_addr    (instr_addr),
        .instr_req     (instr_req),
        .instr_data    (instr_data),
        .instr_ack     (instr_ack),
        .branch        (branch),
        .branch_target (branch_target),
        .fetch         (fetch),
        .fetch_vld     (fetch_vld),
        .fetch_rdy     (fetch_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] fexp(input logic [31:0] a);
        return {a, mem_word(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, clock it, then settle past the edge.
    task automatic cyc(input logic ack, input logic rdy, input logic br, input logic [31:0] tgt);
        instr_ack     = ack;
        fetch_rdy     = rdy;
        branch        = br;
        branch_target = tgt;
        instr_data    = mem_word(instr_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstz          = 1'b0;
        instr_ack     = 1'b0;
        instr_data    = 32'h0;
        branch        = 1'b0;
        branch_target = 32'h0;
        fetch_rdy     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",  {63'h0, instr_req}, 64'h0);
        chk("rst_vld",  {63'h0, fetch_vld}, 64'h0);
        chk("rst_fetch", fetch, 64'h0);
        chk("rst_addr", {32'h0, instr_addr}, 64'h0);

        rstz = 1'b1;
        #1;
        chk("boot_req", {63'h0, instr_req}, 64'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("first_req",  {63'h0, instr_req}, 64'h1);
        chk("first_addr", {32'h0, instr_addr}, 64'h0);

        // Zero-wait memory, decode always ready: one word per cycle
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            chk("zw_fetch", fetch, fexp(32'(i * 4)));
            chk("zw_vld",   {63'h0, fetch_vld}, 64'h1);
        end
        chk("zw_addr", {32'h0, instr_addr}, 64'h10);

        // Ack every third cycle: address held through wait cycles
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            chk("ws_vld0",  {63'h0, fetch_vld}, 64'h0);
            chk("ws_addr0", {32'h0, instr_addr}, {32'h0, 32'(16 + k * 4)});
            chk("ws_req0",  {63'h0, instr_req}, 64'h1);
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            chk("ws_vld1",  {63'h0, fetch_vld}, 64'h0);
            chk("ws_addr1", {32'h0, instr_addr}, {32'h0, 32'(16 + k * 4)});
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            chk("ws_fetch", fetch, fexp(32'(16 + k * 4)));
            chk("ws_vld2",  {63'h0, fetch_vld}, 64'h1);
        end

        // Decode stalled for 5 cycles: word 20 held, word 24 parked, requests stop
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("st_req",   {63'h0, instr_req}, 64'h0);
        chk("st_fetch", fetch, fexp(32'h14));
        chk("st_addr",  {32'h0, instr_addr}, 64'h1C);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            chk("st_hold_req",   {63'h0, instr_req}, 64'h0);
            chk("st_hold_fetch", fetch, fexp(32'h14));
            chk("st_hold_vld",   {63'h0, fetch_vld}, 64'h1);
        end
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("st_drain_fetch", fetch, fexp(32'h18));
        chk("st_drain_vld",   {63'h0, fetch_vld}, 64'h1);
        chk("st_drain_req",   {63'h0, instr_req}, 64'h1);
        chk("st_drain_addr",  {32'h0, instr_addr}, 64'h1C);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("st_next_fetch", fetch, fexp(32'h1C));

        // Branch with ack while a skid word is pending
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("br_stall_req", {63'h0, instr_req}, 64'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'h100);
        chk("br_vld",  {63'h0, fetch_vld}, 64'h0);
        chk("br_addr", {32'h0, instr_addr}, 64'h100);
        chk("br_req",  {63'h0, instr_req}, 64'h1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("br_fetch", fetch, fexp(32'h100));
        chk("br_vld2",  {63'h0, fetch_vld}, 64'h1);

        // Branch coincident with an ack in FETCH: ack discarded
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        chk("bra_vld",  {63'h0, fetch_vld}, 64'h0);
        chk("bra_addr", {32'h0, instr_addr}, 64'h200);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("bra_fetch", fetch, fexp(32'h200));

        // pc wrap at the top of the address space
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        chk("wr_addr", {32'h0, instr_addr}, 64'hFFFF_FFF8);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wr_f0", fetch, fexp(32'hFFFF_FFF8));
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wr_f1", fetch, fexp(32'hFFFF_FFFC));
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wr_f2",   fetch, fexp(32'h0));
        chk("wr_addr2", {32'h0, instr_addr}, 64'h4);

        // Reset in the middle of a wait cycle
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("mr_req_before", {63'h0, instr_req}, 64'h1);
        rstz = 1'b0;
        #2;
        chk("mr_req",   {63'h0, instr_req}, 64'h0);
        chk("mr_vld",   {63'h0, fetch_vld}, 64'h0);
        chk("mr_fetch", fetch, 64'h0);
        chk("mr_addr",  {32'h0, instr_addr}, 64'h0);
        @(posedge clk);
        #1;
        rstz = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("mr_restart_req",  {63'h0, instr_req}, 64'h1);
        chk("mr_restart_addr", {32'h0, instr_addr}, 64'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("mr_restart_fetch", fetch, fexp(32'h0));

        // Branch during BOOT replaces the boot address
        rstz = 1'b0;
        @(posedge clk);
        #1;
        rstz = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 32'h340);
        chk("bb_addr", {32'h0, instr_addr}, 64'h340);
        chk("bb_req",  {63'h0, instr_req}, 64'h1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("bb_fetch", fetch, fexp(32'h340));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
